// File: rtl/counter_pkg.sv
// Shared counter definitions.
// Holds the FSM state encoding used by the down counter and the default
// counter width shared with the 4-bit up counter.
package counter_pkg;

  localparam int unsigned CNT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/sync_down_counter_if.sv
// Control/status bundle for sync_down_counter.
// Signals:
//   load        single-cycle request to capture load_val and (re)start
//   load_val    start/reload value, unsigned, WIDTH bits
//   en          count enable
//   auto_reload 1 = periodic, 0 = one-shot
//   count       registered counter value
//   tc          registered one-cycle terminal-count pulse
//   busy        counter is running
//   done        one-shot has expired
// Modports: master drives the controls, slave is the counter itself.
interface sync_down_counter_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W_DEFAULT
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, en, auto_reload,
    input  count, tc, busy, done
  );

  modport slave (
    input  load, load_val, en, auto_reload,
    output count, tc, busy, done
  );

endinterface

// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter with terminal-count pulse.
// Counts from a loaded value down to zero while enabled, then either stops
// in DONE (one-shot) or reloads and keeps running (periodic).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  slave side of sync_down_counter_if (load, load_val, en,
//        auto_reload in; count, tc, busy, done out)
module sync_down_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  sync_down_counter_if.slave bus
);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic             tc_q, tc_n;
  logic             busy, done;

  // State register: every piece of state shares the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      reload_q <= reload_n;
      tc_q     <= tc_n;
    end
  end

  // Next-state / next-count. Load outranks the terminal event, which
  // outranks a plain decrement; en is ignored on the load cycle.
  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    reload_n = reload_q;
    tc_n     = 1'b0;
    if (bus.load) begin
      count_n  = bus.load_val;
      reload_n = bus.load_val;
      state_n  = (bus.load_val != '0) ? ST_RUN : ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: ;
        ST_RUN: begin
          if (bus.en) begin
            if (count_q == WIDTH'(1)) begin
              tc_n = 1'b1;
              if (bus.auto_reload) begin
                count_n = reload_q;
              end else begin
                count_n = '0;
                state_n = ST_DONE;
              end
            end else begin
              count_n = count_q - WIDTH'(1);
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          count_n = '0;
        end
      endcase
    end
  end

  // Status decoded from the registered state only.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = busy;
  assign bus.done  = done;

endmodule

// File: tb/tb_sync_down_counter.sv
module tb_sync_down_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sync_down_counter_if #(.WIDTH(4)) bus4 ();
  sync_down_counter_if #(.WIDTH(8)) bus8 ();

  sync_down_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  sync_down_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  // Reference model: phase 0 = idle, 1 = running, 2 = expired.
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  int m4_cnt, m4_rel, m4_ph;
  int m8_cnt, m8_rel, m8_ph;
  bit m4_tc, m8_tc;

  task automatic model_reset();
    m4_cnt = 0; m4_rel = 0; m4_ph = P_IDLE; m4_tc = 0;
    m8_cnt = 0; m8_rel = 0; m8_ph = P_IDLE; m8_tc = 0;
  endtask

  task automatic model_step(inout int cnt, inout int rel, inout int ph, output bit tc,
                            input bit ld, input int v, input bit e, input bit ar);
    tc = 0;
    if (ld) begin
      cnt = v;
      rel = v;
      ph  = (v != 0) ? P_RUN : P_DONE;
    end else if (ph == P_RUN && e) begin
      if (cnt == 1) begin
        tc = 1;
        if (ar) cnt = rel;
        else begin
          cnt = 0;
          ph  = P_DONE;
        end
      end else begin
        cnt = cnt - 1;
      end
    end
  endtask

  task automatic set4(input bit ld, input int v, input bit e, input bit ar);
    bus4.load = ld; bus4.load_val = 4'(v); bus4.en = e; bus4.auto_reload = ar;
  endtask

  task automatic set8(input bit ld, input int v, input bit e, input bit ar);
    bus8.load = ld; bus8.load_val = 8'(v); bus8.en = e; bus8.auto_reload = ar;
  endtask

  // One clock: inputs seen at the edge feed the model; sampling at edge+1.
  task automatic tick();
    bit l4, e4, a4, l8, e8, a8;
    int v4, v8;
    l4 = bus4.load; v4 = int'(bus4.load_val); e4 = bus4.en; a4 = bus4.auto_reload;
    l8 = bus8.load; v8 = int'(bus8.load_val); e8 = bus8.en; a8 = bus8.auto_reload;
    @(posedge clk);
    #1;
    if (!rst) model_reset();
    else begin
      model_step(m4_cnt, m4_rel, m4_ph, m4_tc, l4, v4, e4, a4);
      model_step(m8_cnt, m8_rel, m8_ph, m8_tc, l8, v8, e8, a8);
    end
  endtask

  task automatic test_reset();
    logic [6:0]  g4;
    logic [10:0] g8;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set4(i[0], 5, 1, i[1]);
      set8(i[0], 9, 1, 0);
      tick();
      g4 = {bus4.count, bus4.tc, bus4.busy, bus4.done};
      g8 = {bus8.count, bus8.tc, bus8.busy, bus8.done};
      total++;
      if (g4 !== 7'h0 || g8 !== 11'h0) begin
        bad++;
        $display("FAIL reset_hold[%0d] got4=%h got8=%h want 0", i, g4, g8);
      end
    end
    set4(0, 0, 0, 0);
    set8(0, 0, 0, 0);
    #2 rst = 1'b1;
    tick();
    g4 = {bus4.count, bus4.tc, bus4.busy, bus4.done};
    total++;
    if (g4 !== 7'h0) begin
      bad++;
      $display("FAIL reset_release got=%h want=0", g4);
    end
    // Bring the counter to 3 in RUN, then reset between edges.
    set4(1, 5, 0, 0);
    tick();
    set4(0, 0, 1, 0);
    tick();
    tick();
    g4 = {bus4.count, bus4.tc, bus4.busy, bus4.done};
    total++;
    if (g4 !== {4'd3, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_prerun got=%h want=%h", g4, {4'd3, 1'b0, 1'b1, 1'b0});
    end
    #2 rst = 1'b0;
    #1;
    g4 = {bus4.count, bus4.tc, bus4.busy, bus4.done};
    total++;
    if (g4 !== 7'h0) begin
      bad++;
      $display("FAIL reset_async got=%h want=0", g4);
    end
    model_reset();
    set4(0, 0, 0, 0);
    tick();
    #2 rst = 1'b1;
  endtask

  task automatic test_oneshot();
    int exp_c[6] = '{5, 4, 3, 2, 1, 0};
    logic [6:0] g, w;
    for (int i = 0; i < 8; i++) begin
      set4(i == 0, 5, 1, 0);
      tick();
      g = {bus4.count, bus4.tc, bus4.busy, bus4.done};
      w = {4'(exp_c[(i > 5) ? 5 : i]), i == 5, i < 5, i >= 5};
      total++;
      if (g !== w) begin
        bad++;
        $display("FAIL oneshot[%0d] got=%h want=%h", i, g, w);
      end
    end
  endtask

  task automatic test_enable_gaps();
    bit         en_pat[6] = '{1, 0, 0, 1, 1, 1};
    int         exp_c[7] = '{4, 3, 3, 3, 2, 1, 0};
    logic [6:0] g, w;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) set4(1, 4, 1, 0);
      else set4(0, 0, en_pat[i-1], 0);
      tick();
      g = {bus4.count, bus4.tc, bus4.busy, bus4.done};
      w = {4'(exp_c[i]), i == 6, i < 6, i == 6};
      total++;
      if (g !== w) begin
        bad++;
        $display("FAIL en_gaps[%0d] got=%h want=%h", i, g, w);
      end
    end
  endtask

  task automatic test_periodic();
    int exp_c[10] = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
    int pulses = 0;
    logic [6:0] g, w;
    for (int i = 0; i < 10; i++) begin
      set4(i == 0, 3, 1, 1);
      tick();
      if (bus4.tc === 1'b1) pulses++;
      g = {bus4.count, bus4.tc, bus4.busy, bus4.done};
      w = {4'(exp_c[i]), (i % 3 == 0) && (i != 0), 1'b1, 1'b0};
      total++;
      if (g !== w) begin
        bad++;
        $display("FAIL periodic[%0d] got=%h want=%h", i, g, w);
      end
    end
    total++;
    if (pulses != 3) begin
      bad++;
      $display("FAIL periodic_pulses got=%0d want=3", pulses);
    end
    // Reload value 1: tc on every enabled cycle, count pinned at 1.
    set4(1, 1, 1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      set4(0, 0, 1, 1);
      tick();
      g = {bus4.count, bus4.tc, bus4.busy, bus4.done};
      total++;
      if (g !== {4'd1, 1'b1, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL reload_one[%0d] got=%h want=%h", i, g, {4'd1, 1'b1, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_load_priority();
    logic [6:0] g;
    set4(1, 2, 0, 0);
    tick();
    set4(0, 0, 1, 0);
    tick();
    set4(1, 7, 1, 0);
    tick();
    g = {bus4.count, bus4.tc, bus4.busy, bus4.done};
    total++;
    if (g !== {4'd7, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL load_over_tc got=%h want=%h", g, {4'd7, 1'b0, 1'b1, 1'b0});
    end
    set4(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) tick();
    g = {bus4.count, bus4.tc, bus4.busy, bus4.done};
    total++;
    if (g !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL run_to_done got=%h want=%h", g, {4'd0, 1'b0, 1'b0, 1'b1});
    end
    set4(1, 9, 0, 0);
    tick();
    g = {bus4.count, bus4.tc, bus4.busy, bus4.done};
    total++;
    if (g !== {4'd9, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL load_from_done got=%h want=%h", g, {4'd9, 1'b0, 1'b1, 1'b0});
    end
    set4(0, 0, 0, 0);
  endtask

  task automatic test_zero_and_wide();
    logic [10:0] g;
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 4; i++) begin
      set8(i == 0, 0, 1, 1);
      tick();
      g = {bus8.count, bus8.tc, bus8.busy, bus8.done};
      total++;
      if (g !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL zero_load[%0d] got=%h want=%h", i, g, {8'd0, 1'b0, 1'b0, 1'b1});
      end
    end
    set8(1, 200, 1, 0);
    tick();
    set8(0, 0, 1, 0);
    while (!seen && n < 300) begin
      tick();
      n++;
      if (bus8.tc === 1'b1) seen = 1;
      else begin
        total++;
        if (bus8.count !== 8'(200 - n) || bus8.busy !== 1'b1) begin
          bad++;
          $display("FAIL wide_count[%0d] got=%0d busy=%b want=%0d busy=1",
                   n, bus8.count, bus8.busy, 200 - n);
        end
      end
    end
    total++;
    if (!seen || n != 200 || bus8.done !== 1'b1 || bus8.count !== 8'd0) begin
      bad++;
      $display("FAIL wide_tc got seen=%0b n=%0d done=%b count=%0d want seen=1 n=200 done=1 count=0",
               seen, n, bus8.done, bus8.count);
    end
    set8(0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [6:0]  g4, w4;
    logic [10:0] g8, w8;
    for (int i = 0; i < 600; i++) begin
      set4($urandom_range(9) == 0, $urandom_range(15), $urandom_range(3) != 0, $urandom_range(1));
      set8($urandom_range(11) == 0,
           ($urandom_range(7) == 0) ? $urandom_range(255) : $urandom_range(12),
           $urandom_range(3) != 0, $urandom_range(1));
      tick();
      g4 = {bus4.count, bus4.tc, bus4.busy, bus4.done};
      w4 = {4'(m4_cnt), m4_tc, m4_ph == P_RUN, m4_ph == P_DONE};
      g8 = {bus8.count, bus8.tc, bus8.busy, bus8.done};
      w8 = {8'(m8_cnt), m8_tc, m8_ph == P_RUN, m8_ph == P_DONE};
      total++;
      if (g4 !== w4) begin
        bad++;
        $display("FAIL random4[%0d] got=%h want=%h", i, g4, w4);
      end
      total++;
      if (g8 !== w8) begin
        bad++;
        $display("FAIL random8[%0d] got=%h want=%h", i, g8, w8);
      end
    end
  endtask

  initial begin
    model_reset();
    set4(0, 0, 0, 0);
    set8(0, 0, 0, 0);
    test_reset();
    test_oneshot();
    test_enable_gaps();
    test_periodic();
    test_load_priority();
    test_zero_and_wide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
Loadable synchronous down counter with terminal-count signalling. It is the decrementing counterpart to the team's 4-bit synchronous up counter. It counts from a loaded value down to zero under an enable, then either stops (one-shot) or reloads and repeats (periodic). It is used as a countdown/interval timer feeding control FSMs elsewhere in the design.

Parameters:
- WIDTH, 4, counter and load-value width in bits (legal range 2..32).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- load  input  1  single-cycle request: capture load_val and (re)start.
- load_val  input  WIDTH  start/reload value, unsigned.
- en  input  1  count enable; decrement only when high.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled every cycle.
- count  output  WIDTH  current counter value, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE (one-shot expired).

Behaviour:
- Reset (rst=0, any time, asynchronous): count=0, reload_reg=0, tc=0, state=IDLE, so busy=0 and done=0. The block stays in reset while rst is low.
- State register: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE). Both are decoded from the registered state, with no combinational path from inputs.
- tc defaults to 0 every cycle; it is 1 only in the cycle after a terminal event.
- Priority each edge: load > terminal/decrement > hold.
- load=1, any state:
  - count <= load_val, reload_reg <= load_val.
  - load_val != 0: next state RUN.
  - load_val == 0: next state DONE, tc stays 0.
  - en in the same cycle is ignored, so the first decrement happens at the next enabled edge.
  - A load coinciding with a terminal event wins, and no tc is generated.
- RUN, load=0, en=0: hold count, no tc.
- RUN, load=0, en=1, count>1: count <= count-1.
- RUN, load=0, en=1, count==1 (terminal event): tc <= 1.
  - auto_reload=0: count <= 0, next state DONE.
  - auto_reload=1: count <= reload_reg, stay RUN. Period is reload_reg enabled cycles; count never shows 0 in this mode.
  - reload_reg==1 with auto_reload=1: count stays 1 and tc fires every enabled cycle.
- IDLE and DONE: count holds (0 in DONE); en and auto_reload are ignored; only load leaves the state.
- No wrap-around: the block never decrements from 0, since count is only 0 in IDLE/DONE or transiently after load_val=0.
- Latency:
  - load to count visible: 1 cycle.
  - One-shot with load_val=N and en held high: tc and done assert N cycles after the load cycle's edge.
- Arithmetic is unsigned WIDTH-bit; no saturation logic is needed beyond the rules above.
- Illegal state encoding recovers to IDLE with count=0.

Decomposition:
- Shared package counter_pkg holds:
  - state encoding constants: ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10.
  - the default width constant CNT_W_DEFAULT=4, shared with the up counter.
- No sub-module. This is a single flat block: next-state/next-count logic plus one async-reset register process.

Test Plan:
- Reset: hold rst=0 while toggling load/en, then release → count=0, tc=0, busy=0, done=0. Assert rst=0 mid-RUN at count=3 → all outputs 0 immediately, without waiting for a clock edge.
- One-shot: load_val=5, pulse load, en=1, auto_reload=0 → count 5,4,3,2,1,0 on successive edges. tc=1 only in the cycle count first reads 0. done=1 and busy=0 from then on; count holds 0 with en still high.
- Enable gaps: load_val=4, en pattern 1,0,0,1,1,1 → count 4,3,3,3,2,1,0. tc appears once, after the sixth edge.
- Periodic: load_val=3, auto_reload=1, en=1 for 10 cycles → count 3,2,1,3,2,1,3,2,1,3. tc pulses at every 1→3 transition (3 pulses). busy stays 1 and done stays 0.
- Load priority: in RUN with count=1 and en=1, pulse load with load_val=7 → next count=7, tc=0, state RUN. A load of 9 issued from DONE (WIDTH=4) → count=9, busy=1.
- Zero load and WIDTH=8: load_val=0 → count=0, done=1, tc never asserts. With WIDTH=8, load_val=200, one-shot, en=1 → tc exactly 200 cycles after load.
